alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (gate-level NAND/OR/NOT/EXOR datapath) between

---
 rtl/alu_share_if.sv | 33 +++
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Request, shared-ALU and response signals of the ALU sharing arbiter.
// The master side is the requesters, the response consumer and the ALU; the slave side is the arbiter.
interface alu_share_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int OPW   = 3,
   parameter int IDW   = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*OPW-1:0]   req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [OPW-1:0]        alu_op;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [WIDTH-1:0]      alu_y;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  busy;

   modport master (
      output req_valid, req_op, req_a, req_b, alu_y, rsp_ready,
      input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_y, rsp_ready,
      output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters.
// Each granted operation is issued for one cycle, then returned on a valid/ready channel tagged with the requester id.
//
//  state   | meaning
//  S_IDLE  | waiting for a request; grant and latch operands combinationally
//  S_ISSUE | operands driven to the ALU; result captured at the clock edge
//  S_RESP  | response valid, held until rsp_ready
module alu_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int OPW   = 3,
   parameter int IDW   = 2
) (
   input logic        clk,
   input logic        rst_n,
   alu_share_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [NREQ-1:0]  ready_c;
   logic             grant_vld;
   logic [IDW-1:0]   grant_id;
   logic [IDW:0]     cand;

   // Scan from the highest offset down so the candidate closest to rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (|(bus.req_valid & (NREQ'(1) << cand))) begin
            grant_vld = 1'b1;
            grant_id  = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      alu_op_d = alu_op_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      data_d   = data_q;
      ready_c  = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               ready_c  = NREQ'(1) << grant_id;
               alu_op_d = bus.req_op[int'(grant_id)*OPW +: OPW];
               alu_a_d  = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
               alu_b_d  = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
               id_d     = grant_id;
               rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            data_d  = bus.alu_y;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         data_q   <= data_d;
      end
   end

   // Grants are suppressed while reset is asserted, even though the FSM already sits in IDLE.
   assign bus.req_ready = rst_n ? ready_c : '0;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = data_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a stub ALU.
module tb_alu_share_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_share_if #(.NREQ(4), .WIDTH(8), .OPW(3), .IDW(2)) bus ();

   alu_share_arbiter #(.NREQ(4), .WIDTH(8), .OPW(3), .IDW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return ~(a & b);
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   assign bus.alu_y = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.req_op[i*3 +: 3] = op;
      bus.req_a[i*8 +: 8]  = a;
      bus.req_b[i*8 +: 8]  = b;
   endtask

   // One full operation with rsp_ready held high: IDLE grant, ISSUE, RESP.
   task automatic do_op(input logic [3:0] vld, input int g, input logic [7:0] d, input string tag);
      @(negedge clk);
      bus.req_valid = vld;
      bus.rsp_ready = 1'b1;
      #1;
      chk({tag, " grant"}, 32'(bus.req_ready), 32'(1) << g);
      chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, " issue ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, " issue rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, " issue busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk({tag, " resp rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " resp id"}, 32'(bus.rsp_id), 32'(g));
      chk({tag, " resp data"}, 32'(bus.rsp_data), 32'(d));
      bus.req_valid = 4'b0000;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pend;
      logic [2:0] pop[4];
      logic [7:0] pa[4];
      logic [7:0] pb[4];
      logic [7:0] exp_d;
      int rr_m, g, accepted, iters;
      bit done;

      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;

      @(negedge clk);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst alu_op", 32'(bus.alu_op), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hand-computed results: 5A^0F=55, 30|0C=3C, ~(F0&3C)=CF, ~A5=5A
      set_req(0, 3'd3, 8'h5A, 8'h0F);
      set_req(1, 3'd1, 8'h30, 8'h0C);
      set_req(2, 3'd0, 8'hF0, 8'h3C);
      set_req(3, 3'd2, 8'hA5, 8'h00);

      @(negedge clk);
      chk("idle no grant", 32'(bus.req_ready), 32'd0);
      do_op(4'b0001, 0, 8'h55, "single");
      chk("single alu_a", 32'(bus.alu_a), 32'h5A);
      chk("single alu_op", 32'(bus.alu_op), 32'd3);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      do_op(4'b1111, 0, 8'h55, "rr0");
      do_op(4'b1111, 1, 8'h3C, "rr1");
      do_op(4'b1111, 2, 8'hCF, "rr2");
      do_op(4'b1111, 3, 8'h5A, "rr3");
      do_op(4'b1111, 0, 8'h55, "rr4");

      do_op(4'b0100, 2, 8'hCF, "to_rr3");
      do_op(4'b0101, 0, 8'h55, "wrap0");
      do_op(4'b0101, 2, 8'hCF, "skip2");
      do_op(4'b1000, 3, 8'h5A, "to_rr0");
      do_op(4'b1000, 3, 8'h5A, "rr0 grant3");

      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp grant", 32'(bus.req_ready), 32'b0010);
      @(negedge clk);
      bus.req_valid = 4'b1111;
      chk("bp issue ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("bp resp id", 32'(bus.rsp_id), 32'd1);
      chk("bp resp data", 32'(bus.rsp_data), 32'h3C);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp hold ready", 32'(bus.req_ready), 32'd0);
         chk("bp hold valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp hold id", 32'(bus.rsp_id), 32'd1);
         chk("bp hold data", 32'(bus.rsp_data), 32'h3C);
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("bp release busy", 32'(bus.busy), 32'd0);
      chk("bp release valid", 32'(bus.rsp_valid), 32'd0);

      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("midrst resp", 32'(bus.rsp_valid), 32'd1);
      bus.req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("midrst alu_b", 32'(bus.alu_b), 32'd0);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      rst_n = 1'b1;

      pend = '0;
      rr_m = 0;
      accepted = 0;
      iters = 0;
      for (int i = 0; i < 4; i++) begin
         pop[i] = '0;
         pa[i]  = '0;
         pb[i]  = '0;
      end
      while (accepted < 1000 && iters < 12000) begin
         @(negedge clk);
         iters++;
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               pop[i]  = 3'($urandom_range(0, 7));
               pa[i]   = 8'($urandom_range(0, 255));
               pb[i]   = 8'($urandom_range(0, 255));
               set_req(i, pop[i], pa[i], pb[i]);
            end
         end
         bus.req_valid = pend;
         #1;
         g = -1;
         for (int k = 3; k >= 0; k--) begin
            if (pend[(rr_m + k) % 4]) g = (rr_m + k) % 4;
         end
         if (g < 0) begin
            chk("rnd no grant", 32'(bus.req_ready), 32'd0);
            continue;
         end
         chk("rnd grant", 32'(bus.req_ready), 32'(1) << g);
         accepted++;
         exp_d = alu_f(pop[g], pa[g], pb[g]);
         rr_m = (g + 1) % 4;
         @(negedge clk);
         pend[g] = 1'b0;
         bus.req_valid = pend;
         chk("rnd issue ready", 32'(bus.req_ready), 32'd0);
         done = 1'b0;
         for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            chk("rnd resp valid", 32'(bus.rsp_valid), 32'd1);
            chk("rnd resp ready", 32'(bus.req_ready), 32'd0);
            chk("rnd resp id", 32'(bus.rsp_id), 32'(g));
            chk("rnd resp data", 32'(bus.rsp_data), 32'(exp_d));
            bus.rsp_ready = ($urandom_range(0, 3) != 0 || k == 63);
            done = bus.rsp_ready;
         end
      end
      chk("rnd accepted", 32'(accepted), 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
